// File: rtl/pwm_burst_analyzer_pkg.sv
// Shared definitions for the burst PWM generator and analyzer pair.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Contents: default system clock, burst frequency defaults, FSM state encoding.
package pwm_burst_analyzer_pkg;

    // System clock assumed by default parameter computations (Hz).
    localparam int DEF_CLK_SISTEMA_FREQ = 12_000_000;

    // Burst frequencies used by the generator; kept here so both ends agree.
    localparam int DEF_FREQ_A = 1_000;
    localparam int DEF_FREQ_B = 2_500;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_e;

endpackage

// File: rtl/pwm_edge_sync.sv
// Purpose: 2-FF synchronizer for the asynchronous PWM pin plus registered rising-edge detect.
// Latency: rise_o asserts 3 cycles after the pin edge; level_o is aligned with rise_o.
// Backpressure: none, free-running on every clock.
// Ports: clk, rst_n (async active-low), pwm_i (async pin), level_o (synchronized level), rise_o (edge strobe).
module pwm_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_i,
    output logic level_o,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic rise_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= pwm_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            rise_q  <= sync2_q & ~prev_q;
        end
    end

    // prev_q and rise_q load on the same edge, so the level seen in the
    // rise cycle is the high sample that produced the edge.
    assign level_o = prev_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/pwm_burst_analyzer.sv
// Purpose: measures period/high time of each PWM cycle and groups matching periods into bursts.
// Latency: meas_valid 4 cycles after the pin rising edge; mismatch burst_done 1 cycle after meas_valid.
// Backpressure: none; strobes are single-cycle and outputs hold until the next strobe.
// Ports: clk, rst_n, pwm_in -> period_out/high_out/meas_valid, burst_pulses/burst_period/burst_done, signal_lost.
module pwm_burst_analyzer
    import pwm_burst_analyzer_pkg::*;
#(
    parameter int  CLK_SISTEMA_FREQ = DEF_CLK_SISTEMA_FREQ,
    parameter int  TIMEOUT_CYCLES   = (CLK_SISTEMA_FREQ / 5) * 2,
    parameter int  TOL_SHIFT        = 4,
    parameter int  PULSE_WIDTH      = 8,
    localparam int CNT_WIDTH        = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pwm_in,
    output logic [CNT_WIDTH-1:0]   period_out,
    output logic [CNT_WIDTH-1:0]   high_out,
    output logic                   meas_valid,
    output logic [PULSE_WIDTH-1:0] burst_pulses,
    output logic [CNT_WIDTH-1:0]   burst_period,
    output logic                   burst_done,
    output logic                   signal_lost
);

    localparam logic [CNT_WIDTH-1:0]   CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PULSE_WIDTH-1:0] PULSE_ONE = {{(PULSE_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]   TO_LAST   = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic level;
    logic rise;

    pwm_edge_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .pwm_i   (pwm_in),
        .level_o (level),
        .rise_o  (rise)
    );

    // ---------------- measurement FSM ----------------
    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] period_cnt_q, period_cnt_d;
    logic [CNT_WIDTH-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_WIDTH-1:0] period_out_q, period_out_d;
    logic [CNT_WIDTH-1:0] high_out_q, high_out_d;
    logic                 meas_valid_q, meas_valid_d;
    logic                 signal_lost_q;
    logic                 timeout;

    always_comb begin
        state_d      = state_q;
        period_cnt_d = period_cnt_q;
        high_cnt_d   = high_cnt_q;
        period_out_d = period_out_q;
        high_out_d   = high_out_q;
        meas_valid_d = 1'b0;
        timeout      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                period_cnt_d = '0;
                high_cnt_d   = '0;
                // First edge only arms the counters; there is no prior edge to measure from.
                if (rise) begin
                    high_cnt_d = CNT_ONE;
                    state_d    = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (rise) begin
                    // +1 accounts for the rise cycle itself, which the counter never sees.
                    period_out_d = period_cnt_q + 1'b1;
                    high_out_d   = high_cnt_q;
                    meas_valid_d = 1'b1;
                    period_cnt_d = '0;
                    high_cnt_d   = CNT_ONE;
                end else if (period_cnt_q == TO_LAST) begin
                    timeout      = 1'b1;
                    period_cnt_d = '0;
                    high_cnt_d   = '0;
                    state_d      = ST_IDLE;
                end else begin
                    period_cnt_d = period_cnt_q + 1'b1;
                    high_cnt_d   = high_cnt_q + {{(CNT_WIDTH-1){1'b0}}, level};
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            period_cnt_q  <= '0;
            high_cnt_q    <= '0;
            period_out_q  <= '0;
            high_out_q    <= '0;
            meas_valid_q  <= 1'b0;
            signal_lost_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            period_cnt_q  <= period_cnt_d;
            high_cnt_q    <= high_cnt_d;
            period_out_q  <= period_out_d;
            high_out_q    <= high_out_d;
            meas_valid_q  <= meas_valid_d;
            signal_lost_q <= timeout;
        end
    end

    // ---------------- burst compare stage ----------------
    // Works on the registered measurement, so a mismatch reports one cycle
    // after its meas_valid. A timeout can never coincide with meas_valid_q
    // because the period counter restarts on every rise.
    logic [CNT_WIDTH-1:0]   ref_per_q, ref_per_d;
    logic [PULSE_WIDTH-1:0] pulse_cnt_q, pulse_cnt_d;
    logic [PULSE_WIDTH-1:0] burst_pulses_q, burst_pulses_d;
    logic [CNT_WIDTH-1:0]   burst_period_q, burst_period_d;
    logic                   burst_done_q, burst_done_d;
    logic [CNT_WIDTH:0]     per_diff;
    logic [CNT_WIDTH:0]     per_tol;

    always_comb begin
        ref_per_d      = ref_per_q;
        pulse_cnt_d    = pulse_cnt_q;
        burst_pulses_d = burst_pulses_q;
        burst_period_d = burst_period_q;
        burst_done_d   = 1'b0;
        per_diff = (period_out_q >= ref_per_q) ? ({1'b0, period_out_q} - {1'b0, ref_per_q})
                                               : ({1'b0, ref_per_q} - {1'b0, period_out_q});
        per_tol  = {1'b0, ref_per_q >> TOL_SHIFT};
        if (timeout) begin
            if (pulse_cnt_q != '0) begin
                burst_pulses_d = pulse_cnt_q;
                burst_period_d = ref_per_q;
                burst_done_d   = 1'b1;
            end
            pulse_cnt_d = '0;
        end else if (meas_valid_q) begin
            if (pulse_cnt_q == '0) begin
                ref_per_d   = period_out_q;
                pulse_cnt_d = PULSE_ONE;
            end else if (per_diff <= per_tol) begin
                if (pulse_cnt_q != '1) begin
                    pulse_cnt_d = pulse_cnt_q + 1'b1;
                end
            end else begin
                burst_pulses_d = pulse_cnt_q;
                burst_period_d = ref_per_q;
                burst_done_d   = 1'b1;
                ref_per_d      = period_out_q;
                pulse_cnt_d    = PULSE_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_per_q      <= '0;
            pulse_cnt_q    <= '0;
            burst_pulses_q <= '0;
            burst_period_q <= '0;
            burst_done_q   <= 1'b0;
        end else begin
            ref_per_q      <= ref_per_d;
            pulse_cnt_q    <= pulse_cnt_d;
            burst_pulses_q <= burst_pulses_d;
            burst_period_q <= burst_period_d;
            burst_done_q   <= burst_done_d;
        end
    end

    assign period_out   = period_out_q;
    assign high_out     = high_out_q;
    assign meas_valid   = meas_valid_q;
    assign burst_pulses = burst_pulses_q;
    assign burst_period = burst_period_q;
    assign burst_done   = burst_done_q;
    assign signal_lost  = signal_lost_q;

endmodule

// File: tb/tb_pwm_burst_analyzer.sv
// Bench for pwm_burst_analyzer: drives PWM periods, records every strobe with its cycle
// stamp, and compares against event lists derived from the rising-edge times of the stimulus.
// Timing reference: outputs are sampled on the falling clock edge.
module tb_pwm_burst_analyzer;

    localparam int TMO = 64;
    localparam int TOL = 3;
    localparam int CW  = $clog2(TMO + 1);
    localparam int PW  = 8;
    localparam int SAT = (1 << PW) - 1;
    localparam int NO_CUT = 32'h7fff_ffff;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          pwm_in = 1'b0;
    logic [CW-1:0] period_out;
    logic [CW-1:0] high_out;
    logic          meas_valid;
    logic [PW-1:0] burst_pulses;
    logic [CW-1:0] burst_period;
    logic          burst_done;
    logic          signal_lost;

    pwm_burst_analyzer #(
        .TIMEOUT_CYCLES (TMO),
        .TOL_SHIFT      (TOL),
        .PULSE_WIDTH    (PW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pwm_in       (pwm_in),
        .period_out   (period_out),
        .high_out     (high_out),
        .meas_valid   (meas_valid),
        .burst_pulses (burst_pulses),
        .burst_period (burst_period),
        .burst_done   (burst_done),
        .signal_lost  (signal_lost)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int t;
        int a;
        int b;
    } ev_t;

    function automatic ev_t mk_ev(input int t, input int a, input int b);
        ev_t e;
        e.t = t;
        e.a = a;
        e.b = b;
        return e;
    endfunction

    // Stimulus record: cycle at which pwm_in was raised, and the high width of that period.
    int  rise_t[$];
    int  rise_h[$];
    ev_t got_m[$], got_b[$], exp_m[$], exp_b[$];
    int  got_l[$], exp_l[$];

    int n_chk = 0;
    int n_err = 0;
    int hold_bad = 0;
    int last_per = 0;
    int last_hi = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Monitor: record strobes and watch that measurements hold between strobes.
    always @(negedge clk) begin
        if (meas_valid) got_m.push_back(mk_ev(cyc, int'(period_out), int'(high_out)));
        if (burst_done) got_b.push_back(mk_ev(cyc, int'(burst_pulses), int'(burst_period)));
        if (signal_lost) got_l.push_back(cyc);
        if (!rst_n) begin
            last_per <= 0;
            last_hi  <= 0;
        end else if (meas_valid) begin
            last_per <= int'(period_out);
            last_hi  <= int'(high_out);
        end else if (int'(period_out) != last_per || int'(high_out) != last_hi) begin
            hold_bad <= hold_bad + 1;
        end
    end

    // Reference: from the edge times alone. Pin edge at cycle r is seen as a
    // measurement at r+4; a gap longer than TMO means the signal was lost
    // 4+TMO cycles after the previous edge and the next edge only re-arms.
    task automatic build_expected(input int cut);
        int have_prev;
        int rprev;
        int hprev;
        int rf;
        int cnt;
        have_prev = 0; rprev = 0; hprev = 0; rf = 0; cnt = 0;
        exp_m.delete(); exp_b.delete(); exp_l.delete();
        for (int i = 0; i < rise_t.size(); i++) begin
            int r;
            int g;
            int d;
            r = rise_t[i];
            g = r - rprev;
            if (have_prev != 0 && g <= TMO) begin
                if (r + 4 < cut) exp_m.push_back(mk_ev(r + 4, g, hprev));
                d = (g > rf) ? g - rf : rf - g;
                if (cnt == 0) begin
                    rf = g; cnt = 1;
                end else if (d <= (rf >> TOL)) begin
                    cnt = (cnt < SAT) ? cnt + 1 : SAT;
                end else begin
                    if (r + 5 < cut) exp_b.push_back(mk_ev(r + 5, cnt, rf));
                    rf = g; cnt = 1;
                end
            end else if (have_prev != 0) begin
                if (rprev + TMO + 4 < cut) begin
                    exp_l.push_back(rprev + TMO + 4);
                    if (cnt > 0) exp_b.push_back(mk_ev(rprev + TMO + 4, cnt, rf));
                end
                cnt = 0;
            end
            have_prev = 1; rprev = r; hprev = rise_h[i];
        end
        // Every segment ends with the pin held low, so the last edge times out.
        if (have_prev != 0 && rprev + TMO + 4 < cut) begin
            exp_l.push_back(rprev + TMO + 4);
            if (cnt > 0) exp_b.push_back(mk_ev(rprev + TMO + 4, cnt, rf));
        end
    endtask

    task automatic start_seg();
        rise_t.delete(); rise_h.delete();
        got_m.delete(); got_b.delete(); got_l.delete();
    endtask

    task automatic end_seg(input string name, input int cut);
        build_expected(cut);
        check_eq({name, ".n_meas"}, got_m.size(), exp_m.size());
        for (int i = 0; i < exp_m.size() && i < got_m.size(); i++) begin
            check_eq($sformatf("%s.meas%0d.cyc", name, i), got_m[i].t, exp_m[i].t);
            check_eq($sformatf("%s.meas%0d.period", name, i), got_m[i].a, exp_m[i].a);
            check_eq($sformatf("%s.meas%0d.high", name, i), got_m[i].b, exp_m[i].b);
        end
        check_eq({name, ".n_burst"}, got_b.size(), exp_b.size());
        for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
            check_eq($sformatf("%s.burst%0d.cyc", name, i), got_b[i].t, exp_b[i].t);
            check_eq($sformatf("%s.burst%0d.pulses", name, i), got_b[i].a, exp_b[i].a);
            check_eq($sformatf("%s.burst%0d.period", name, i), got_b[i].b, exp_b[i].b);
        end
        check_eq({name, ".n_lost"}, got_l.size(), exp_l.size());
        for (int i = 0; i < exp_l.size() && i < got_l.size(); i++)
            check_eq($sformatf("%s.lost%0d.cyc", name, i), got_l[i], exp_l[i]);
    endtask

    task automatic drive_period(input int p, input int h);
        rise_t.push_back(cyc);
        rise_h.push_back(h);
        pwm_in = 1'b1;
        repeat (h) @(posedge clk);
        #1;
        pwm_in = 1'b0;
        repeat (p - h) @(posedge clk);
        #1;
    endtask

    task automatic hold_low(input int n);
        pwm_in = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string name);
        check_eq({name, ".period_out"}, period_out, 0);
        check_eq({name, ".high_out"}, high_out, 0);
        check_eq({name, ".meas_valid"}, meas_valid, 0);
        check_eq({name, ".burst_pulses"}, burst_pulses, 0);
        check_eq({name, ".burst_period"}, burst_period, 0);
        check_eq({name, ".burst_done"}, burst_done, 0);
        check_eq({name, ".signal_lost"}, signal_lost, 0);
    endtask

    initial begin
        int cut;
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        // Pin toggling under reset must leave every output at 0.
        start_seg();
        for (int i = 0; i < 12; i++) begin
            pwm_in = (i % 3 == 0) ? 1'b1 : 1'b0;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check_zero("in_reset");
        pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("in_reset.no_strobe", got_m.size() + got_b.size() + got_l.size(), 0);

        // Steady 10-cycle periods, 5 high.
        start_seg();
        repeat (5) drive_period(10, 5);
        hold_low(80);
        end_seg("steady10", NO_CUT);

        // Frequency change 10 -> 20.
        start_seg();
        repeat (4) drive_period(10, 5);
        repeat (3) drive_period(20, 7);
        hold_low(80);
        end_seg("change", NO_CUT);

        // Tolerance edge: 17 and 18 are within 16>>3, 19 is not.
        start_seg();
        drive_period(16, 8); drive_period(17, 8); drive_period(18, 9); drive_period(19, 9);
        hold_low(80);
        end_seg("tolerance", NO_CUT);

        // Signal loss, then a lone edge that only re-arms.
        start_seg();
        repeat (4) drive_period(10, 5);
        hold_low(80);
        repeat (2) drive_period(10, 4);
        hold_low(80);
        end_seg("lost", NO_CUT);

        // Timeout boundary: a 64 gap is measured, a 65 gap is lost.
        start_seg();
        drive_period(64, 30); drive_period(64, 30); drive_period(65, 30);
        drive_period(10, 5); drive_period(10, 5);
        hold_low(80);
        end_seg("boundary", NO_CUT);

        // Pulse counter saturation.
        start_seg();
        repeat (260) drive_period(3, 1);
        hold_low(80);
        end_seg("saturate", NO_CUT);

        // Reset in the middle of a burst: partial burst vanishes.
        start_seg();
        repeat (3) drive_period(12, 6);
        rise_t.push_back(cyc);
        rise_h.push_back(6);
        pwm_in = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        cut = cyc;
        @(negedge clk);
        check_zero("mid_reset");
        pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold_low(80);
        end_seg("mid_reset", cut);

        start_seg();
        repeat (4) drive_period(12, 6);
        hold_low(80);
        end_seg("after_reset", NO_CUT);

        // Random bursts with jitter and occasional long gaps.
        for (int s = 0; s < 6; s++) begin
            int nb;
            start_seg();
            nb = $urandom_range(2, 4);
            for (int b = 0; b < nb; b++) begin
                int base;
                int n;
                base = $urandom_range(2, 40);
                n = $urandom_range(1, 5);
                for (int k = 0; k < n; k++) begin
                    int p;
                    int h;
                    p = base;
                    if (base >= 16) p = base + int'($urandom_range(0, 2)) - 1;
                    h = $urandom_range(1, p - 1);
                    drive_period(p, h);
                end
                if ($urandom_range(0, 3) == 0) hold_low($urandom_range(55, 75));
            end
            hold_low(80);
            end_seg($sformatf("rand%0d", s), NO_CUT);
        end

        check_eq("meas_hold", hold_bad, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
